// File: rtl/mems_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mems_pkg
//  Description : Shared types and constants for the MEMS DAC SPI arbiter:
//                DAC word width, arbiter FSM encoding and owner encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mems_pkg;

  // Width of one DAC command word shifted by the SPI master
  localparam int DAC_WORD_W = 24;

  // Arbiter FSM states, explicitly encoded in two bits
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } arb_state_e;

  // Owner of the last/current transfer
  localparam logic OWN_SCAN = 1'b0;
  localparam logic OWN_CFG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mems_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mems_spi_arbiter
//  Description : Shares one MEMS DAC SPI master between the scan sequencer
//                (priority) and the configuration path. The config path is
//                guaranteed a slot after MAX_SCAN_GRANTS consecutive scan
//                grants, and a bounded wait flags a master that never goes busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mems_spi_arbiter
  import mems_pkg::*;
#(
  parameter int DATA_W          = DAC_WORD_W,
  parameter int MAX_SCAN_GRANTS = 8,
  parameter int BUSY_TIMEOUT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              scan_req,
  input  logic [DATA_W-1:0] scan_data,
  output logic              scan_ack,
  input  logic              cfg_req,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ack,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_busy,
  output logic              owner,
  output logic              arb_idle,
  output logic              err_timeout
);

  localparam int c_streak_w = $clog2(MAX_SCAN_GRANTS + 1);
  localparam int c_timer_w  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_SCAN_GRANTS);
  localparam logic [c_timer_w-1:0]  c_timer_last = c_timer_w'(BUSY_TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [c_streak_w-1:0]   streak_q, streak_d;
  logic [c_timer_w-1:0]    timer_q, timer_d;
  logic                    spi_start_q, spi_start_d;
  logic [DATA_W-1:0]       spi_data_q, spi_data_d;
  logic                    scan_ack_q, scan_ack_d;
  logic                    cfg_ack_q, cfg_ack_d;
  logic                    owner_q, owner_d;
  logic                    arb_idle_q, arb_idle_d;
  logic                    err_q, err_d;

  logic                    w_sv;
  logic                    w_cv;
  logic                    w_grant_scan;
  logic                    w_grant_cfg;

  // Grant selection: only when idle with the SPI master quiet; scan wins
  // unless the config path has already waited out its streak budget.
  always_comb begin
    w_sv         = scan_req & ~pause;
    w_cv         = cfg_req;
    w_grant_scan = 1'b0;
    w_grant_cfg  = 1'b0;
    if ((state_q == ST_IDLE) && !spi_busy) begin
      if (w_sv && w_cv) begin
        if (streak_q < c_streak_max) begin
          w_grant_scan = 1'b1;
        end else begin
          w_grant_cfg = 1'b1;
        end
      end else if (w_sv) begin
        w_grant_scan = 1'b1;
      end else if (w_cv) begin
        w_grant_cfg = 1'b1;
      end
    end
  end

  // Streak of scan grants taken while config is pending; saturates at the budget.
  always_comb begin
    streak_d = streak_q;
    if (!cfg_req || w_grant_cfg) begin
      streak_d = '0;
    end else if (w_grant_scan && (streak_q < c_streak_max)) begin
      streak_d = streak_q + c_streak_w'(1);
    end
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    spi_start_d = 1'b0;
    scan_ack_d  = 1'b0;
    cfg_ack_d   = 1'b0;
    spi_data_d  = spi_data_q;
    owner_d     = owner_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant_scan || w_grant_cfg) begin
          spi_data_d  = w_grant_cfg ? cfg_data : scan_data;
          owner_d     = w_grant_cfg ? OWN_CFG : OWN_SCAN;
          spi_start_d = 1'b1;
          scan_ack_d  = w_grant_scan;
          cfg_ack_d   = w_grant_cfg;
          timer_d     = '0;
          state_d     = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (spi_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == c_timer_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + c_timer_w'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    arb_idle_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops any pending start/ack at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      spi_start_q <= 1'b0;
      spi_data_q  <= '0;
      scan_ack_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
      owner_q     <= OWN_SCAN;
      arb_idle_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      scan_ack_q  <= scan_ack_d;
      cfg_ack_q   <= cfg_ack_d;
      owner_q     <= owner_d;
      arb_idle_q  <= arb_idle_d;
      err_q       <= err_d;
    end
  end

  assign spi_start   = spi_start_q;
  assign spi_data    = spi_data_q;
  assign scan_ack    = scan_ack_q;
  assign cfg_ack     = cfg_ack_q;
  assign owner       = owner_q;
  assign arb_idle    = arb_idle_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mems_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mems_spi_arbiter
//  Description : Self-checking bench for mems_spi_arbiter with a simple SPI
//                master model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mems_spi_arbiter;
  import mems_pkg::*;

  localparam int DW   = 24;
  localparam int MAXG = 2;
  localparam int TMO  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pause;
  logic          scan_req;
  logic [DW-1:0] scan_data;
  logic          scan_ack;
  logic          cfg_req;
  logic [DW-1:0] cfg_data;
  logic          cfg_ack;
  logic          spi_start;
  logic [DW-1:0] spi_data;
  logic          spi_busy;
  logic          owner;
  logic          arb_idle;
  logic          err_timeout;

  always #5 clk = ~clk;

  mems_spi_arbiter #(
    .DATA_W         (DW),
    .MAX_SCAN_GRANTS(MAXG),
    .BUSY_TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pause      (pause),
    .scan_req   (scan_req),
    .scan_data  (scan_data),
    .scan_ack   (scan_ack),
    .cfg_req    (cfg_req),
    .cfg_data   (cfg_data),
    .cfg_ack    (cfg_ack),
    .spi_start  (spi_start),
    .spi_data   (spi_data),
    .spi_busy   (spi_busy),
    .owner      (owner),
    .arb_idle   (arb_idle),
    .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // SPI master model: busy window [start+dly, start+dly+len-1]
  bit slave_on   = 1'b0;
  bit rand_busy  = 1'b0;
  bit force_busy = 1'b0;
  int fix_dly    = 1;
  int fix_len    = 2;
  int s_dly      = 1;
  int s_len      = 1;
  int busy_from  = 1;
  int busy_to    = 0;

  // Advance one cycle, sample just after the edge, update the SPI master model
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (slave_on && spi_start) begin
      if (rand_busy) begin
        s_dly = int'($urandom_range(1, 3));
        s_len = int'($urandom_range(1, 5));
      end else begin
        s_dly = fix_dly;
        s_len = fix_len;
      end
      busy_from = cyc + s_dly;
      busy_to   = busy_from + s_len - 1;
    end
    spi_busy = force_busy || ((cyc >= busy_from) && (cyc <= busy_to));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pause = 1'b0; scan_req = 1'b0; cfg_req = 1'b0;
    scan_data = '0; cfg_data = '0; spi_busy = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({spi_start, scan_ack, cfg_ack, owner, arb_idle, err_timeout} !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b",
               {spi_start, scan_ack, cfg_ack, owner, arb_idle, err_timeout}, 6'b000010);
    end
    n_checks++;
    if (spi_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want %h", spi_data, 24'h0);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({spi_start, arb_idle} !== 2'b01) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", {spi_start, arb_idle}, 2'b01);
    end
  endtask

  task automatic test_single_scan();
    int starts;
    int acks;
    starts = 0; acks = 0;
    slave_on = 1'b1; rand_busy = 1'b0; fix_dly = 2; fix_len = 10;
    scan_data = 24'h300800; scan_req = 1'b1;
    step();
    n_checks++;
    if ({spi_start, scan_ack, cfg_ack, owner, arb_idle, spi_data} !== {5'b11000, 24'h300800}) begin
      n_fail++;
      $display("FAIL single_launch: got %b/%h want 11000/300800",
               {spi_start, scan_ack, cfg_ack, owner, arb_idle}, spi_data);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) scan_req = 1'b0;
      if (spi_start) starts++;
      if (scan_ack || cfg_ack) acks++;
      if (i == 12) begin
        n_checks++;
        if (arb_idle !== 1'b0) begin
          n_fail++; $display("FAIL single_busy_phase: arb_idle got %b want 0", arb_idle);
        end
      end
      if (i == 13) begin
        n_checks++;
        if (arb_idle !== 1'b1) begin
          n_fail++; $display("FAIL single_return_idle: arb_idle got %b want 1", arb_idle);
        end
      end
    end
    n_checks++;
    if (starts !== 0 || acks !== 0 || spi_data !== 24'h300800) begin
      n_fail++;
      $display("FAIL single_extra: starts %0d acks %0d data %h want 0 0 300800", starts, acks, spi_data);
    end
  endtask

  task automatic test_fairness();
    bit [5:0]      seq;
    int            got;
    bit            s_next;
    logic [DW-1:0] sword;
    seq = 6'b100100; got = 0; s_next = 1'b0;
    slave_on = 1'b1; rand_busy = 1'b1;
    sword = DW'($urandom); scan_data = sword; cfg_data = 24'h280001;
    scan_req = 1'b1; cfg_req = 1'b1;
    for (int i = 0; i < 300 && got < 6; i++) begin
      step();
      if (s_next) begin
        s_next = 1'b0; sword = DW'($urandom); scan_data = sword;
      end
      if (spi_start) begin
        n_checks++;
        if ({owner, scan_ack, cfg_ack} !== {seq[got], !seq[got], seq[got]}) begin
          n_fail++;
          $display("FAIL fair_owner[%0d]: got owner/sack/cack %b want %b", got,
                   {owner, scan_ack, cfg_ack}, {seq[got], !seq[got], seq[got]});
        end
        n_checks++;
        if (spi_data !== (seq[got] ? 24'h280001 : sword)) begin
          n_fail++;
          $display("FAIL fair_data[%0d]: got %h want %h", got, spi_data,
                   (seq[got] ? 24'h280001 : sword));
        end
        if (!owner) s_next = 1'b1;
        got++;
      end
    end
    n_checks++;
    if (got !== 6) begin
      n_fail++; $display("FAIL fair_count: got %0d transfers want 6", got);
    end
    scan_req = 1'b0; cfg_req = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_pause();
    int            cfg_grants;
    int            scan_acks;
    logic [DW-1:0] w;
    cfg_grants = 0; scan_acks = 0;
    slave_on = 1'b1; rand_busy = 1'b1;
    w = DW'($urandom);
    pause = 1'b1; scan_req = 1'b1; scan_data = w; cfg_req = 1'b1; cfg_data = DW'($urandom);
    for (int i = 0; i < 100 && cfg_grants < 2; i++) begin
      step();
      if (scan_ack) scan_acks++;
      if (spi_start) begin
        n_checks++;
        if ({owner, cfg_ack} !== 2'b11) begin
          n_fail++; $display("FAIL pause_owner: got owner/cack %b want 11", {owner, cfg_ack});
        end
        if (cfg_ack) cfg_grants++;
      end
    end
    step();
    cfg_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (scan_ack) scan_acks++;
    end
    n_checks++;
    if (cfg_grants !== 2 || scan_acks !== 0) begin
      n_fail++;
      $display("FAIL pause_block: cfg grants %0d scan acks %0d want 2 0", cfg_grants, scan_acks);
    end
    pause = 1'b0;
    step();
    n_checks++;
    if ({spi_start, scan_ack, owner, spi_data} !== {3'b110, w}) begin
      n_fail++;
      $display("FAIL pause_release: got %b/%h want 110/%h", {spi_start, scan_ack, owner}, spi_data, w);
    end
    step();
    scan_req = 1'b0;
    repeat (15) step();
  endtask

  // Random traffic against a transaction-level model: grant on the cycle after
  // the arbiter becomes free, free again two cycles after busy ends.
  task automatic test_random();
    bit            p_sv, p_cv, exp_start, exp_own, s_hold, c_hold;
    logic [DW-1:0] p_sd, p_cd, exp_data;
    int            m_streak;
    int            elig;
    m_streak = 0; elig = cyc; s_hold = 1'b0; c_hold = 1'b0;
    slave_on = 1'b1; rand_busy = 1'b1;
    p_sv = scan_req & ~pause; p_cv = cfg_req; p_sd = scan_data; p_cd = cfg_data;
    for (int i = 0; i < 600; i++) begin
      step();
      exp_start = (cyc >= elig) && (p_sv || p_cv);
      n_checks++;
      if (spi_start !== exp_start) begin
        n_fail++; $display("FAIL rand_start @%0d: got %b want %b", cyc, spi_start, exp_start);
      end
      if (exp_start) begin
        exp_own  = p_sv ? (p_cv && (m_streak >= MAXG)) : 1'b1;
        exp_data = exp_own ? p_cd : p_sd;
        n_checks++;
        if ({owner, scan_ack, cfg_ack, spi_data} !== {exp_own, !exp_own, exp_own, exp_data}) begin
          n_fail++;
          $display("FAIL rand_grant @%0d: got %b/%h want %b/%h", cyc,
                   {owner, scan_ack, cfg_ack}, spi_data, {exp_own, !exp_own, exp_own}, exp_data);
        end
        elig = cyc + s_dly + s_len + 2;
      end else begin
        n_checks++;
        if ({scan_ack, cfg_ack} !== 2'b00) begin
          n_fail++; $display("FAIL rand_ack @%0d: got %b want 00", cyc, {scan_ack, cfg_ack});
        end
      end
      if (!p_cv || (exp_start && exp_own)) m_streak = 0;
      else if (exp_start && m_streak < MAXG) m_streak++;
      n_checks++;
      if (arb_idle !== (cyc >= elig - 1)) begin
        n_fail++; $display("FAIL rand_idle @%0d: got %b want %b", cyc, arb_idle, (cyc >= elig - 1));
      end
      if (scan_ack) s_hold = 1'b1;
      else if (s_hold) begin
        s_hold = 1'b0;
        if ($urandom_range(0, 1) == 1) scan_data = DW'($urandom); else scan_req = 1'b0;
      end else if (scan_req) begin
        if ($urandom_range(0, 31) == 0) scan_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        scan_req = 1'b1; scan_data = DW'($urandom);
      end
      if (cfg_ack) c_hold = 1'b1;
      else if (c_hold) begin
        c_hold = 1'b0;
        if ($urandom_range(0, 1) == 1) cfg_data = DW'($urandom); else cfg_req = 1'b0;
      end else if (cfg_req) begin
        if ($urandom_range(0, 31) == 0) cfg_req = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        cfg_req = 1'b1; cfg_data = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      p_sv = scan_req & ~pause; p_cv = cfg_req; p_sd = scan_data; p_cd = cfg_data;
    end
    scan_req = 1'b0; cfg_req = 1'b0; pause = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rand_err: got %b want 0", err_timeout);
    end
    repeat (15) step();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] w;
    slave_on = 1'b0;
    scan_data = DW'($urandom); scan_req = 1'b1;
    step();
    n_checks++;
    if (spi_start !== 1'b1) begin
      n_fail++; $display("FAIL to_start: got %b want 1", spi_start);
    end
    step();
    scan_req = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({err_timeout, arb_idle} !== 2'b00) begin
      n_fail++; $display("FAIL to_early: err/idle got %b want 00", {err_timeout, arb_idle});
    end
    step();
    n_checks++;
    if ({err_timeout, arb_idle} !== 2'b11) begin
      n_fail++; $display("FAIL to_flag: err/idle got %b want 11", {err_timeout, arb_idle});
    end
    slave_on = 1'b1; rand_busy = 1'b0; fix_dly = 1; fix_len = 2;
    w = DW'($urandom); cfg_data = w; cfg_req = 1'b1;
    step();
    n_checks++;
    if ({spi_start, cfg_ack, owner, spi_data} !== {3'b111, w}) begin
      n_fail++;
      $display("FAIL to_next: got %b/%h want 111/%h", {spi_start, cfg_ack, owner}, spi_data, w);
    end
    step();
    cfg_req = 1'b0;
    repeat (10) step();
    n_checks++;
    if ({err_timeout, arb_idle} !== 2'b11) begin
      n_fail++; $display("FAIL to_sticky: err/idle got %b want 11", {err_timeout, arb_idle});
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] w;
    int            bto;
    int            found;
    slave_on = 1'b1; rand_busy = 1'b0; fix_dly = 1; fix_len = 8;
    w = DW'($urandom) | 24'h000001; scan_data = w; scan_req = 1'b1;
    step();
    n_checks++;
    if (spi_start !== 1'b1) begin
      n_fail++; $display("FAIL ar_start: got %b want 1", spi_start);
    end
    repeat (4) step();
    n_checks++;
    if ({arb_idle, err_timeout} !== 2'b01) begin
      n_fail++; $display("FAIL ar_pre: idle/err got %b want 01", {arb_idle, err_timeout});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_start, scan_ack, cfg_ack, owner, arb_idle, err_timeout, spi_data} !== {6'b000010, 24'h0}) begin
      n_fail++;
      $display("FAIL ar_reset: got %b/%h want 000010/000000",
               {spi_start, scan_ack, cfg_ack, owner, arb_idle, err_timeout}, spi_data);
    end
    step();
    rst_n = 1'b1;
    bto = busy_to; found = -1;
    for (int i = 0; i < 30 && found < 0; i++) begin
      step();
      if (spi_start) found = cyc;
    end
    n_checks++;
    if (found !== bto + 2) begin
      n_fail++; $display("FAIL ar_regrant_time: got cycle %0d want %0d", found, bto + 2);
    end
    n_checks++;
    if ({owner, scan_ack, spi_data} !== {2'b01, w}) begin
      n_fail++; $display("FAIL ar_regrant: got %b/%h want 01/%h", {owner, scan_ack}, spi_data, w);
    end
    step();
    scan_req = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_busy_in_idle();
    logic [DW-1:0] w;
    int            bad;
    bad = 0;
    slave_on = 1'b0; force_busy = 1'b1; spi_busy = 1'b1;
    w = DW'($urandom); scan_data = w; scan_req = 1'b1;
    repeat (5) begin
      step();
      if (spi_start) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bi_hold: got %0d starts want 0", bad);
    end
    force_busy = 1'b0; spi_busy = 1'b0;
    slave_on = 1'b1; rand_busy = 1'b0; fix_dly = 1; fix_len = 2;
    step();
    n_checks++;
    if ({spi_start, scan_ack, owner, spi_data} !== {3'b110, w}) begin
      n_fail++;
      $display("FAIL bi_start: got %b/%h want 110/%h", {spi_start, scan_ack, owner}, spi_data, w);
    end
    step();
    scan_req = 1'b0;
    repeat (10) step();
    n_checks++;
    if (arb_idle !== 1'b1) begin
      n_fail++; $display("FAIL bi_idle: got %b want 1", arb_idle);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_fairness();
    test_pause();
    test_random();
    test_timeout();
    test_async_reset();
    test_busy_in_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
